// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 byte transmitter. Performs the request-to-send
//   sequence (clock inhibit, data low, clock release), then shifts out
//   8 data bits LSB first, odd parity and stop on device clock falling
//   edges, samples the device ACK and waits for both lines to be released.
//
//   Parameters:
//     INHIBIT_CYCLES  clocks PS2C is held low for request-to-send (>= 2)
//     TIMEOUT_CYCLES  max clocks between device PS2C falling edges
//     FILTER_LEN      consecutive identical PS2C samples to accept a level
//
//   Ports:
//     clk, rst_n          system clock, synchronous active-low reset
//     tx_start, tx_data   one-cycle send request and command byte
//     PS2C, PS2D          asynchronous PS/2 line levels
//     ps2c_oe, ps2d_oe    open-drain pull-low enables (1 = drive low)
//     tx_busy             high from accepted request until back in idle
//     tx_done, tx_err     one-cycle completion / timeout-or-NACK pulses
//
//   Build option:
//     PS2_TX_ACK_CHECK_EN  when defined, an ACK sample of 1 ends the frame
//                          with tx_err instead of tx_done.

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, WAIT_REL} state_t;

    // Line conditioning
    logic          c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    logic          c_flt_q, fall_q;
    logic [FW-1:0] flt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_s1_q    <= 1'b1;
            c_s2_q    <= 1'b1;
            d_s1_q    <= 1'b1;
            d_s2_q    <= 1'b1;
            c_flt_q   <= 1'b1;
            fall_q    <= 1'b0;
            flt_cnt_q <= '0;
        end else begin
            c_s1_q <= PS2C;
            c_s2_q <= c_s1_q;
            d_s1_q <= PS2D;
            d_s2_q <= d_s1_q;
            fall_q <= 1'b0;
            // Count consecutive samples that disagree with the accepted
            // level; the FILTER_LEN-th one flips it.
            if (c_s2_q == c_flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                c_flt_q   <= c_s2_q;
                flt_cnt_q <= '0;
                fall_q    <= c_flt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // Transmit FSM
    state_t        state_q, state_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [3:0]    bit_q, bit_d, n;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic          busy_q, done_q, done_d, err_q, err_d;
`ifdef PS2_TX_ACK_CHECK_EN
    logic          nack_q, nack_d;
`endif

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        wd_d    = wd_q;
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        n       = bit_q + 4'd1;
`ifdef PS2_TX_ACK_CHECK_EN
        nack_d  = nack_q;
`endif
        case (state_q)
            IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (tx_start) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    icnt_d  = '0;
                    c_oe_d  = 1'b1;
                    state_d = INHIBIT;
`ifdef PS2_TX_ACK_CHECK_EN
                    nack_d  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                icnt_d = icnt_q + 1'b1;
                // Outputs are registered, so decide one count early.
                if (icnt_q == IW'(INHIBIT_CYCLES - 2)) begin
                    d_oe_d = 1'b1;
                end
                if (icnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    state_d = RTS;
                end
            end
            RTS: begin
                bit_d   = '0;
                wd_d    = '0;
                state_d = BITS;
            end
            BITS: begin
                if (fall_q) begin
                    wd_d  = '0;
                    bit_d = n;
                    if (n <= 4'd8) begin
                        d_oe_d = ~data_q[bit_q[2:0]];
                    end else if (n == 4'd9) begin
                        d_oe_d = ~par_q;
                    end else if (n == 4'd10) begin
                        d_oe_d = 1'b0;
                    end else begin
`ifdef PS2_TX_ACK_CHECK_EN
                        nack_d = d_s2_q;
`endif
                        d_oe_d  = 1'b0;
                        state_d = WAIT_REL;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WAIT_REL: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (c_flt_q && d_s2_q) begin
                    state_d = IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    err_d   = nack_q;
                    done_d  = ~nack_q;
`else
                    done_d  = 1'b1;
`endif
                end else if (fall_q) begin
                    wd_d = '0;
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            icnt_q  <= '0;
            wd_q    <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            nack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            wd_q    <= wd_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
            nack_q  <= nack_d;
`endif
        end
    end

    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The module SHALL have parameter INHIBIT_CYCLES, default 5000, clocks PS2C is held low for request-to-send (100 us at 50 MHz).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clocks allowed between consecutive device PS2C falling edges (15 ms at 50 MHz).
REQ-003 The module SHALL have parameter FILTER_LEN, default 8, consecutive identical synchronized PS2C samples required before a level is accepted.
REQ-004 Port list, one per line, clock and reset first:
- clk  input  1  Basys2 50 MHz system clock; all logic clocked on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_start  input  1  one-cycle request to send tx_data; honoured only when tx_busy=0.
- tx_data  input  8  command byte to send (e.g. 0xED set-LEDs, 0xFF reset).
- PS2C  input  1  PS/2 clock line level, asynchronous.
- PS2D  input  1  PS/2 data line level, asynchronous.
- ps2c_oe  output  1  1 = pull PS2C low (open-drain); 0 = release.
- ps2d_oe  output  1  1 = pull PS2D low (open-drain); 0 = release.
- tx_busy  output  1  high from accepted tx_start until return to IDLE.
- tx_done  output  1  one-cycle pulse on successful completion.
- tx_err  output  1  one-cycle pulse on timeout or NACK; never coincident with tx_done.

Function
REQ-005 PS2C and PS2D SHALL each pass through a 2-flop synchronizer. PS2C SHALL additionally pass through a FILTER_LEN-sample stability filter; a "falling edge" is the filtered level going 1->0, one cycle wide.
REQ-006 FSM states SHALL be IDLE, INHIBIT, RTS, BITS, WAIT_REL.
REQ-007 IDLE: ps2c_oe=0, ps2d_oe=0, tx_busy=0. On tx_start=1, latch tx_data, compute odd parity (parity = ~^tx_data), go to INHIBIT. tx_busy SHALL be 1 on the next cycle.
REQ-008 INHIBIT: ps2c_oe=1 for exactly INHIBIT_CYCLES clocks. ps2d_oe SHALL be set to 1 during the final clock of INHIBIT, then go to RTS.
REQ-009 RTS: ps2c_oe=0, ps2d_oe=1 (start bit 0). Clear bit counter to 0, go to BITS.
REQ-010 BITS: on each falling edge, increment the counter n and drive PS2D:
- n=1..8: ps2d_oe = ~tx_data[n-1] (LSB first).
- n=9: ps2d_oe = ~parity.
- n=10: ps2d_oe=0 (stop bit).
- n=11: sample synchronized PS2D as the ACK bit, then go to WAIT_REL.
REQ-011 WAIT_REL: both lines released. When filtered PS2C=1 and synchronized PS2D=1, go to IDLE and pulse tx_done, or tx_err if a NACK was recorded (REQ-018).
REQ-012 Watchdog: a counter clears on every falling edge and on entry to BITS. In BITS or WAIT_REL, reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_err and go to IDLE on the following cycle.
REQ-013 tx_start while tx_busy=1 SHALL be ignored; the latched byte SHALL be unchanged.
REQ-014 A PS2C rising edge SHALL never change ps2d_oe; PS2D changes only on falling edges, or on RTS/IDLE entry.
REQ-015 All outputs SHALL be registered; ps2c_oe and ps2d_oe SHALL never both be 1 except in the last INHIBIT cycle and in RTS.

Reset
REQ-016 When rst_n=0 at a clk edge:
- State goes to IDLE.
- ps2c_oe=0, ps2d_oe=0, tx_busy=0, tx_done=0, tx_err=0.
- Counters, synchronizers and filter reset to 0, with synchronizers and filter set to 1 (line-idle level).
REQ-017 Reset asserted mid-transfer SHALL release both lines on that same edge; no tx_done or tx_err pulse is emitted for the aborted byte.

Configuration
REQ-018 Macro PS2_TX_ACK_CHECK_EN:
- Defined: an ACK sample of 1 at n=11 records a NACK; completion then pulses tx_err instead of tx_done.
- Undefined: the ACK bit is ignored and completion always pulses tx_done, unless a timeout occurred.

Verification
REQ-019 Send 0xED; device model clocks at 12.5 kHz and ACKs -> PS2D bits observed on rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse; tx_busy returns to 0.
REQ-020 Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; ps2c_oe is high for exactly 5000 clocks before release.
REQ-021 Send 0xFF; device never clocks -> tx_err pulses 750000 clocks after RTS, lines released, tx_done never asserted.
REQ-022 Device model drives ACK=1:
- With PS2_TX_ACK_CHECK_EN defined -> tx_err pulse.
- With the macro undefined -> tx_done pulse.
REQ-023 A second tx_start=0x00 issued during bit 4 of 0x01 -> the frame continues as 0x01 (parity 0); exactly one completion pulse.
REQ-024 rst_n=0 asserted after the 6th falling edge -> both oe low on that edge; no done/err pulse; a subsequent 0xED transfer succeeds.
